// File: rtl/npu_mac_seq.sv
`timescale 1ns/1ps
// npu_mac_seq: address/strobe sequencer for one MAC engine evaluating a
// fully-connected layer (N dot products of length L) against 1-cycle RAMs.
module npu_mac_seq #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned NEU_W      = 6,
   parameter int unsigned W_ADDR_W   = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [LEN_W-1:0]      cfg_vec_len,
   input  logic [NEU_W-1:0]      cfg_num_neurons,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  mem_rd_en,
   output logic [W_ADDR_W-1:0]   w_addr,
   output logic [LEN_W-1:0]      a_addr,
   output logic                  mac_en,
   output logic                  start_p,
   output logic                  last_p,
   input  logic                  mac_valid,
   input  logic [DATA_WIDTH-1:0] mac_out,
   input  logic                  mac_overflow,
   output logic                  res_valid,
   output logic [NEU_W-1:0]      res_addr,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_ovf,
   output logic [NEU_W-1:0]      ovf_count
);

   localparam int unsigned OVF_DLY    = 3;
   localparam int unsigned FLUSH_W    = 2;
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(3);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FLUSH = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      len_q;
   logic [NEU_W-1:0]      num_q;
   logic [LEN_W-1:0]      k_q;
   logic [NEU_W-1:0]      n_q;
   logic [W_ADDR_W-1:0]   w_addr_q;
   logic                  mem_rd_en_q;
   logic                  mac_en_q, start_p_q, last_p_q;
   logic [OVF_DLY-1:0]    vld_pipe_q, fst_pipe_q;
   logic                  flag_q, flag_d;
   logic                  res_valid_q, res_ovf_q;
   logic [NEU_W-1:0]      res_addr_q, res_cnt_q, ovf_count_q;
   logic [DATA_WIDTH-1:0] res_data_q;
   logic                  busy_q, done_q, err_q;
   logic [FLUSH_W-1:0]    flush_cnt_q;

   logic cfg_ok_c, accept_c, reject_c, active_c, abort_c;
   logic first_c, last_c, final_issue_c, issue_ok_c;
   logic mac_acc_c, run_done_c, flush_end_c;
   logic [LEN_W-1:0] len_last_c;
   logic [NEU_W-1:0] num_last_c;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state decode; abort has priority over normal progress
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept_c) state_d = S_RUN;
         S_RUN: begin
            if (abort_c)            state_d = S_FLUSH;
            else if (final_issue_c) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort_c)         state_d = S_FLUSH;
            else if (run_done_c) state_d = S_IDLE;
         end
         S_FLUSH: if (flush_end_c) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control decode shared by the FSM and the datapath registers
   always_comb begin
      len_last_c    = LEN_W'(len_q - LEN_W'(1));
      num_last_c    = NEU_W'(num_q - NEU_W'(1));
      cfg_ok_c      = (cfg_vec_len != '0) && (cfg_num_neurons != '0);
      accept_c      = (state_q == S_IDLE) && start && cfg_ok_c;
      reject_c      = (state_q == S_IDLE) && start && !cfg_ok_c;
      active_c      = (state_q == S_RUN) || (state_q == S_DRAIN);
      abort_c       = active_c && abort;
      first_c       = (k_q == '0);
      last_c        = (k_q == len_last_c);
      final_issue_c = mem_rd_en_q && last_c && (n_q == num_last_c);
      issue_ok_c    = mem_rd_en_q && !abort_c;
      mac_acc_c     = active_c && mac_valid && !abort_c;
      run_done_c    = (state_q == S_DRAIN) && res_valid_q && (res_addr_q == num_last_c) && !abort_c;
      flush_end_c   = (state_q == S_FLUSH) && (flush_cnt_q == FLUSH_LAST);
      // First element of a neuron reloads the sticky flag, later ones accumulate
      flag_d = flag_q;
      if (vld_pipe_q[OVF_DLY-1]) begin
         flag_d = fst_pipe_q[OVF_DLY-1] ? mac_overflow : (flag_q | mac_overflow);
      end
   end

   // Issue stage: config latch, k/n counters and incrementing weight address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q       <= '0;
         num_q       <= '0;
         k_q         <= '0;
         n_q         <= '0;
         w_addr_q    <= '0;
         mem_rd_en_q <= 1'b0;
      end else if (accept_c) begin
         len_q       <= cfg_vec_len;
         num_q       <= cfg_num_neurons;
         k_q         <= '0;
         n_q         <= '0;
         w_addr_q    <= '0;
         mem_rd_en_q <= 1'b1;
      end else if (mem_rd_en_q) begin
         if (abort_c || final_issue_c) begin
            mem_rd_en_q <= 1'b0;
         end else begin
            w_addr_q <= W_ADDR_W'(w_addr_q + W_ADDR_W'(1));
            if (last_c) begin
               k_q <= '0;
               n_q <= NEU_W'(n_q + NEU_W'(1));
            end else begin
               k_q <= LEN_W'(k_q + LEN_W'(1));
            end
         end
      end
   end

   // MAC strobes (one cycle behind issue, aligned with RAM data) and overflow tracking pipe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mac_en_q   <= 1'b0;
         start_p_q  <= 1'b0;
         last_p_q   <= 1'b0;
         vld_pipe_q <= '0;
         fst_pipe_q <= '0;
         flag_q     <= 1'b0;
      end else begin
         mac_en_q   <= issue_ok_c;
         start_p_q  <= issue_ok_c && first_c;
         last_p_q   <= issue_ok_c && last_c;
         vld_pipe_q <= {vld_pipe_q[OVF_DLY-2:0], issue_ok_c};
         fst_pipe_q <= {fst_pipe_q[OVF_DLY-2:0], issue_ok_c && first_c};
         flag_q     <= accept_c ? 1'b0 : flag_d;
      end
   end

   // Result capture, overflow statistics and run status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         res_cnt_q   <= '0;
         ovf_count_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         flush_cnt_q <= '0;
      end else begin
         res_valid_q <= mac_acc_c;
         done_q      <= run_done_c;
         err_q       <= reject_c;
         if (mac_acc_c) begin
            res_addr_q <= res_cnt_q;
            res_data_q <= mac_out;
            res_ovf_q  <= flag_d | mac_overflow;
            res_cnt_q  <= NEU_W'(res_cnt_q + NEU_W'(1));
         end
         if (accept_c) begin
            res_cnt_q   <= '0;
            ovf_count_q <= '0;
         end else if (res_valid_q && res_ovf_q && (ovf_count_q != '1)) begin
            ovf_count_q <= NEU_W'(ovf_count_q + NEU_W'(1));
         end
         if (accept_c)                      busy_q <= 1'b1;
         else if (run_done_c || flush_end_c) busy_q <= 1'b0;
         if (abort_c)                   flush_cnt_q <= '0;
         else if (state_q == S_FLUSH)   flush_cnt_q <= FLUSH_W'(flush_cnt_q + FLUSH_W'(1));
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_rd_en = mem_rd_en_q;
   assign w_addr    = w_addr_q;
   assign a_addr    = k_q;
   assign mac_en    = mac_en_q;
   assign start_p   = start_p_q;
   assign last_p    = last_p_q;
   assign res_valid = res_valid_q;
   assign res_addr  = res_addr_q;
   assign res_data  = res_data_q;
   assign res_ovf   = res_ovf_q;
   assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_npu_mac_seq.sv
`timescale 1ns/1ps
// tb_npu_mac_seq: directed bench with behavioural RAMs and a Q2.5 MAC model.
module tb_npu_mac_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort;
   logic [7:0]  cfg_vec_len;
   logic [5:0]  cfg_num_neurons;
   logic        busy, done, err, mem_rd_en, mac_en, start_p, last_p;
   logic [13:0] w_addr;
   logic [7:0]  a_addr;
   logic        mac_valid, mac_overflow;
   logic [7:0]  mac_out;
   logic        res_valid, res_ovf;
   logic [5:0]  res_addr, ovf_count;
   logic [7:0]  res_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   npu_mac_seq dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_vec_len(cfg_vec_len), .cfg_num_neurons(cfg_num_neurons),
      .busy(busy), .done(done), .err(err),
      .mem_rd_en(mem_rd_en), .w_addr(w_addr), .a_addr(a_addr),
      .mac_en(mac_en), .start_p(start_p), .last_p(last_p),
      .mac_valid(mac_valid), .mac_out(mac_out), .mac_overflow(mac_overflow),
      .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
      .res_ovf(res_ovf), .ovf_count(ovf_count)
   );

   // Behavioural RAMs and MAC: 16-bit saturating accumulator, Q2.5 output by truncation
   logic [7:0] wmem [16384];
   logic [7:0] amem [256];
   logic [7:0] rd_w, rd_a, out1;
   logic       v1, ovf1;
   int         acc, sum_c, sat_val_c;
   logic       sat_c;

   always_comb begin
      sum_c     = (start_p ? 0 : acc) + int'($signed(rd_w)) * int'($signed(rd_a));
      sat_c     = 1'b0;
      sat_val_c = sum_c;
      if (sum_c > 32767) begin
         sat_val_c = 32767;
         sat_c     = 1'b1;
      end else if (sum_c < -32768) begin
         sat_val_c = -32768;
         sat_c     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_w <= '0; rd_a <= '0; acc <= 0; v1 <= 1'b0; ovf1 <= 1'b0; out1 <= '0;
         mac_valid <= 1'b0; mac_overflow <= 1'b0; mac_out <= '0;
      end else begin
         if (mem_rd_en) begin
            rd_w <= wmem[w_addr];
            rd_a <= amem[a_addr];
         end
         v1   <= mac_en && last_p;
         ovf1 <= mac_en && sat_c;
         if (mac_en) begin
            acc  <= sat_val_c;
            out1 <= 8'(sat_val_c >>> 5);
         end
         mac_valid    <= v1;
         mac_overflow <= ovf1;
         mac_out      <= out1;
      end
   end

   // Per-cycle observation log of one run (cycle 0 = first issue cycle)
   logic lg_rd [64], lg_men [64], lg_sp [64], lg_lp [64], lg_busy [64];
   int   lg_wa [64], lg_aa [64], lg_ovc [64];
   int   rv_cyc [16], rv_addr [16], rv_data [16], rv_ovf [16];
   int   rv_cnt, done_cyc, done_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [7:0] val);
      for (int i = 0; i < 16384; i++) wmem[i] = val;
      for (int i = 0; i < 256; i++)   amem[i] = val;
   endtask

   task automatic run_seq(input int len, input int num, input int abort_at,
                          input int restart_at, input int budget);
      rv_cnt = 0; done_cyc = -1; done_cnt = 0;
      @(posedge clk); #1;
      cfg_vec_len = 8'(len); cfg_num_neurons = 6'(num); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         abort = (c == abort_at);
         if (c == restart_at) begin
            start = 1'b1; cfg_vec_len = 8'd2; cfg_num_neurons = 6'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lg_rd[c] = mem_rd_en; lg_men[c] = mac_en; lg_sp[c] = start_p; lg_lp[c] = last_p;
         lg_busy[c] = busy; lg_wa[c] = int'(w_addr); lg_aa[c] = int'(a_addr);
         lg_ovc[c] = int'(ovf_count);
         if (res_valid) begin
            if (rv_cnt < 16) begin
               rv_cyc[rv_cnt] = c; rv_addr[rv_cnt] = int'(res_addr);
               rv_data[rv_cnt] = int'(res_data); rv_ovf[rv_cnt] = int'(res_ovf);
            end
            rv_cnt++;
         end
         if (done) begin
            done_cyc = c;
            done_cnt++;
         end
         @(posedge clk); #1;
      end
      abort = 1'b0; start = 1'b0;
   endtask

   task automatic err_try(input int len, input int num, input string tag);
      @(posedge clk); #1;
      cfg_vec_len = 8'(len); cfg_num_neurons = 6'(num); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_err"}, err, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rd"}, mem_rd_en, 0);
      @(negedge clk);
      chk({tag, "_err_clr"}, err, 0);
      chk({tag, "_rd2"}, mem_rd_en, 0);
   endtask

   // Standard L=4, N=3 run with 0x20 operands
   task automatic check_l4n3(input string tag);
      chk({tag, "_wa0"}, lg_wa[0], 0);
      chk({tag, "_nres"}, rv_cnt, 3);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_rv_cyc"}, rv_cyc[i], 7 + 4 * i);
         chk({tag, "_rv_addr"}, rv_addr[i], i);
         chk({tag, "_rv_data"}, rv_data[i], 32'h80);
         chk({tag, "_rv_ovf"}, rv_ovf[i], 0);
      end
      chk({tag, "_done_cyc"}, done_cyc, 16);
      chk({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_vec_len = '0; cfg_num_neurons = '0;
      fill(8'h20);
      #23;
      chk("reset_ctl", {busy, done, err, mem_rd_en, mac_en, start_p, last_p, res_valid, res_ovf}, 0);
      chk("reset_addr", {w_addr, a_addr}, 0);
      chk("reset_res", {res_addr, res_data, ovf_count}, 0);
      @(negedge clk); rst = 1'b1;

      // L=4 N=3, with an ignored start while busy at cycle 3
      run_seq(4, 3, -1, 3, 20);
      check_l4n3("t1");
      chk("t1_sp1", lg_sp[1], 1);
      chk("t1_sp2", lg_sp[2], 0);
      chk("t1_lp4", lg_lp[4], 1);
      chk("t1_aa6", lg_aa[6], 2);
      chk("t1_wa11", lg_wa[11], 11);
      chk("t1_rd11", lg_rd[11], 1);
      chk("t1_rd12", lg_rd[12], 0);
      chk("t1_busy15", lg_busy[15], 1);
      chk("t1_busy16", lg_busy[16], 0);

      // L=1 N=2: first and last coincide
      run_seq(1, 2, -1, -1, 10);
      chk("t2_sp1", lg_sp[1], 1);
      chk("t2_lp1", lg_lp[1], 1);
      chk("t2_sp2", lg_sp[2], 1);
      chk("t2_lp2", lg_lp[2], 1);
      chk("t2_wa0", lg_wa[0], 0);
      chk("t2_wa1", lg_wa[1], 1);
      chk("t2_nres", rv_cnt, 2);
      chk("t2_rv0_cyc", rv_cyc[0], 4);
      chk("t2_rv1_cyc", rv_cyc[1], 5);
      chk("t2_rv1_addr", rv_addr[1], 1);
      chk("t2_rv0_data", rv_data[0], 32'h20);
      chk("t2_done_cyc", done_cyc, 6);

      // L=8 N=2 saturating operands, then a clean run clears the count
      fill(8'h7F);
      run_seq(8, 2, -1, -1, 24);
      chk("t3_nres", rv_cnt, 2);
      chk("t3_rv0_ovf", rv_ovf[0], 1);
      chk("t3_rv1_ovf", rv_ovf[1], 1);
      chk("t3_rv0_data", rv_data[0], 32'hFF);
      chk("t3_rv1_cyc", rv_cyc[1], 19);
      chk("t3_done_cyc", done_cyc, 20);
      chk("t3_ovfcnt", lg_ovc[20], 2);
      fill(8'h01);
      run_seq(8, 2, -1, -1, 24);
      chk("t3b_ovfcnt0", lg_ovc[0], 0);
      chk("t3b_rv0_ovf", rv_ovf[0], 0);
      chk("t3b_rv1_ovf", rv_ovf[1], 0);
      chk("t3b_rv0_data", rv_data[0], 0);
      chk("t3b_ovfcnt", lg_ovc[20], 0);

      // Rejected starts
      err_try(0, 3, "t4_len0");
      err_try(4, 0, "t4_num0");

      // Abort at cycle 5 of L=4 N=4, then a normal run
      fill(8'h20);
      run_seq(4, 4, 5, -1, 16);
      chk("t5_rd5", lg_rd[5], 1);
      chk("t5_rd6", lg_rd[6], 0);
      chk("t5_men6", lg_men[6], 0);
      chk("t5_nres", rv_cnt, 0);
      chk("t5_done_cnt", done_cnt, 0);
      chk("t5_busy9", lg_busy[9], 1);
      chk("t5_busy10", lg_busy[10], 0);
      run_seq(4, 3, -1, -1, 20);
      check_l4n3("t5b");

      // Asynchronous reset mid-run, then a full run from w_addr 0
      @(posedge clk); #1;
      cfg_vec_len = 8'd4; cfg_num_neurons = 6'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("t6_pre_rd", mem_rd_en, 1);
      rst = 1'b0;
      #1;
      chk("t6_rst_ctl", {busy, done, err, mem_rd_en, mac_en, start_p, last_p, res_valid, res_ovf}, 0);
      chk("t6_rst_addr", {w_addr, a_addr}, 0);
      chk("t6_rst_res", {res_addr, res_data, ovf_count}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_seq(4, 3, -1, -1, 20);
      check_l4n3("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
